// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU request arbiter.
// Function codes, default widths/latencies and FSM encoding.
package alu_pkg;

    localparam int REG_DATA_WIDTH_DEF    = 16;
    localparam int ALU_CONTROL_WIDTH_DEF = 4;
    localparam int MUL_CYCLES_DEF        = 2;
    localparam int DIV_CYCLES_DEF        = 4;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Two-way round-robin selector; the pointer flips once per
// completed operation and names the winner when both request.
import alu_pkg::*;

module rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    output logic o_valid,
    output logic o_sel
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~r_ptr;
        end
    end

    assign o_valid = i_req0 | i_req1;
    assign o_sel   = (i_req0 && i_req1) ? r_ptr : i_req1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with
// per-op latency, divide-by-zero bypass and registered outputs.
import alu_pkg::*;

module alu_arbiter #(
    parameter int REG_DATA_WIDTH    = REG_DATA_WIDTH_DEF,
    parameter int ALU_CONTROL_WIDTH = ALU_CONTROL_WIDTH_DEF,
    parameter int MUL_CYCLES        = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES        = DIV_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0,
    input  logic                         req1,
    input  logic [ALU_CONTROL_WIDTH-1:0] op0,
    input  logic [ALU_CONTROL_WIDTH-1:0] op1,
    input  logic [REG_DATA_WIDTH-1:0]    a0,
    input  logic [REG_DATA_WIDTH-1:0]    b0,
    input  logic [REG_DATA_WIDTH-1:0]    a1,
    input  logic [REG_DATA_WIDTH-1:0]    b1,
    output logic                         gnt0,
    output logic                         gnt1,
    output logic                         done0,
    output logic                         done1,
    output logic [REG_DATA_WIDTH-1:0]    r_out,
    output logic [REG_DATA_WIDTH-1:0]    s_out,
    output logic                         exc_out,
    output logic [REG_DATA_WIDTH-1:0]    alu_a,
    output logic [REG_DATA_WIDTH-1:0]    alu_b,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [REG_DATA_WIDTH-1:0]    alu_r,
    input  logic [REG_DATA_WIDTH-1:0]    alu_s,
    input  logic                         alu_exc
);

    localparam logic [ALU_CONTROL_WIDTH-1:0] C_MUL = ALU_CONTROL_WIDTH'(OP_MUL);
    localparam logic [ALU_CONTROL_WIDTH-1:0] C_DIV = ALU_CONTROL_WIDTH'(OP_DIV);

    state_t                         r_state;
    logic [3:0]                     r_cnt;
    logic                           r_sel;

    logic                           w_valid;
    logic                           w_sel;
    logic                           w_dz;
    logic                           w_upd;
    logic [3:0]                     w_lat;
    logic [ALU_CONTROL_WIDTH-1:0]   w_op;
    logic [REG_DATA_WIDTH-1:0]      w_a;
    logic [REG_DATA_WIDTH-1:0]      w_b;

    assign w_upd = (r_state == ST_DONE);

    rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_upd   (w_upd),
        .o_valid (w_valid),
        .o_sel   (w_sel)
    );

    assign w_op = w_sel ? op1 : op0;
    assign w_a  = w_sel ? a1  : a0;
    assign w_b  = w_sel ? b1  : b0;
    assign w_dz = (w_op == C_DIV) && (w_b == '0);

    always_comb begin
        w_lat = 4'd1;
        if (w_op == C_MUL) begin
            w_lat = 4'(MUL_CYCLES);
        end else if (w_op == C_DIV) begin
            w_lat = 4'(DIV_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            r_out       <= '0;
            s_out       <= '0;
            exc_out     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_sel <= w_sel;
                        gnt0  <= ~w_sel;
                        gnt1  <= w_sel;
                        // Divide by zero never reaches the ALU.
                        if (w_dz) begin
                            r_state <= ST_DONE;
                            r_out   <= '0;
                            s_out   <= '0;
                            exc_out <= 1'b1;
                            done0   <= ~w_sel;
                            done1   <= w_sel;
                        end else begin
                            r_state     <= ST_EXEC;
                            r_cnt       <= w_lat;
                            alu_control <= w_op;
                            alu_a       <= w_a;
                            alu_b       <= w_b;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= ST_DONE;
                        r_out       <= alu_r;
                        s_out       <= alu_s;
                        exc_out     <= alu_exc;
                        alu_control <= '0;
                        done0       <= ~r_sel;
                        done1       <= r_sel;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
